// File: rtl/cpu_pkg.sv
// Shared pipeline types for the EX/MEM -> MEM/WB boundary and the memory-access FSM.
// The misalignment helper is kept here so every stage judges word alignment identically.
package cpu_pkg;

  typedef struct packed {
    logic [31:0] ALU_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
  } ex_mem_data_t;

  typedef struct packed {
    logic MEM_read;
    logic MEM_write;
    logic WB_reg_write;
    logic WB_mem_to_reg;
  } ex_mem_control_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic [31:0] ALU_result;
    logic [4:0]  rd;
  } mem_wb_data_t;

  typedef struct packed {
    logic WB_reg_write;
    logic WB_mem_to_reg;
  } mem_wb_control_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } mau_state_t;

  localparam int TIMEOUT_CNT_W = 8;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait counter for an outstanding data-memory request; expire is combinational and
// flags the cycle whose unacknowledged edge would bring the count up to LIMIT.
module mem_timeout_counter
  import cpu_pkg::*;
#(
  parameter int LIMIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [TIMEOUT_CNT_W-1:0] CNT_MAX  = TIMEOUT_CNT_W'(LIMIT);
  localparam logic [TIMEOUT_CNT_W-1:0] CNT_LAST = TIMEOUT_CNT_W'(LIMIT - 1);

  logic [TIMEOUT_CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  assign expire = enable && !clear && (count_q == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: ALU results pass through combinationally; aligned loads/stores stall the pipe,
// run one bus request (N cycles to ack, or timeout), then emit one RESP cycle into MEM_WB.
module mem_access_unit
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  ex_mem_data_t    data_in,
  input  ex_mem_control_t control_in,
  output mem_wb_data_t    data_out,
  output mem_wb_control_t control_out,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            mem_fault
);

  mau_state_t      state_d, state_q;
  logic            mem_req_d, mem_req_q;
  logic            mem_we_d, mem_we_q;
  logic [31:0]     mem_addr_d, mem_addr_q;
  logic [31:0]     mem_wdata_d, mem_wdata_q;
  logic            mem_fault_d, mem_fault_q;
  logic [4:0]      rd_d, rd_q;
  logic [31:0]     rdata_d, rdata_q;
  logic            is_load_d, is_load_q;
  mem_wb_control_t ctrl_d, ctrl_q;

  logic is_mem, misaligned, accept, misalign_fault, timeout_expire;

  assign is_mem         = control_in.MEM_read | control_in.MEM_write;
  assign misaligned     = is_misaligned(data_in.ALU_result);
  assign accept         = (state_q == IDLE) && in_valid && is_mem && !misaligned;
  assign misalign_fault = (state_q == IDLE) && in_valid && is_mem && misaligned;

  mem_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clock  (clock),
    .reset  (reset),
    .clear  (accept),
    .enable ((state_q == ACCESS) && !mem_ack),
    .expire (timeout_expire)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_fault_d = 1'b0;
    rd_d        = rd_q;
    rdata_d     = rdata_q;
    is_load_d   = is_load_q;
    ctrl_d      = ctrl_q;

    data_out    = '{read_data: '0, ALU_result: data_in.ALU_result, rd: data_in.rd};
    control_out = '0;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          stall       = 1'b1;
          state_d     = ACCESS;
          mem_req_d   = 1'b1;
          mem_we_d    = control_in.MEM_write;
          mem_addr_d  = data_in.ALU_result;
          mem_wdata_d = control_in.MEM_write ? data_in.write_data : 32'h0;
          rd_d        = data_in.rd;
          rdata_d     = '0;
          is_load_d   = !control_in.MEM_write;
          ctrl_d      = '{WB_reg_write: control_in.WB_reg_write,
                          WB_mem_to_reg: control_in.WB_mem_to_reg};
        end else if (in_valid) begin
          // Misaligned accesses flow on as harmless no-write instructions.
          control_out.WB_reg_write  = control_in.WB_reg_write && !misalign_fault;
          control_out.WB_mem_to_reg = control_in.WB_mem_to_reg;
        end
      end
      ACCESS: begin
        stall = 1'b1;
        if (mem_ack) begin
          if (is_load_q) begin
            rdata_d = mem_rdata;
          end
          mem_req_d = 1'b0;
          state_d   = RESP;
        end else if (timeout_expire) begin
          mem_req_d           = 1'b0;
          mem_fault_d         = 1'b1;
          ctrl_d.WB_reg_write = 1'b0;
          state_d             = RESP;
        end
      end
      RESP: begin
        data_out    = '{read_data: rdata_q, ALU_result: mem_addr_q, rd: rd_q};
        control_out = ctrl_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must release the upstream freeze immediately, not at the next edge.
    if (reset) begin
      stall = 1'b0;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_fault = mem_fault_q | (misalign_fault & ~reset);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_fault_q <= 1'b0;
      rd_q        <= '0;
      rdata_q     <= '0;
      is_load_q   <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_fault_q <= mem_fault_d;
      rd_q        <= rd_d;
      rdata_q     <= rdata_d;
      is_load_q   <= is_load_d;
      ctrl_q      <= ctrl_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: driver queues one expected MEM_WB result per
// non-stalled cycle, a monitor pops on every such cycle, and a memory model checks the bus.
module tb_mem_access_unit;
  import cpu_pkg::*;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid;
  ex_mem_data_t    data_in;
  ex_mem_control_t control_in;
  mem_wb_data_t    data_out;
  mem_wb_control_t control_out;
  logic            stall, mem_req, mem_we, mem_ack, mem_fault;
  logic [31:0]     mem_addr, mem_wdata, mem_rdata;

  always #5 clock = ~clock;

  mem_access_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .control_in  (control_in),
    .data_out    (data_out),
    .control_out (control_out),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_fault   (mem_fault)
  );

  typedef struct {
    mem_wb_control_t ctrl;
    mem_wb_data_t    data;
    logic            chk_data;
    logic            fault;
    string           name;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  bit          done = 1'b0;
  int          ack_at = 0;
  int          req_cnt = 0;
  logic [31:0] ack_rdata = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wdata = '0;
  logic        exp_we = 1'b0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Memory model: acks on the ack_at-th request cycle (0 = never) and checks bus stability.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = 32'hBAD0_0BAD;
      if (!reset && !done && mem_req) begin
        req_cnt++;
        check("bus_addr", 128'(mem_addr), 128'(exp_addr));
        check("bus_we", 128'(mem_we), 128'(exp_we));
        check("bus_wdata", 128'(mem_wdata), 128'(exp_wdata));
        if (req_cnt == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = ack_rdata;
        end
      end
    end
  end

  // Monitor: every non-stalled cycle out of reset is one MEM_WB result to score.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset && !done) begin
        if (stall) begin
          check("fault_while_stalled", 128'(mem_fault), 128'(0));
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: ctrl=%0h data=%0h with no expected entry",
                   control_out, data_out);
        end else begin
          mon_e = exp_q.pop_front();
          check({mon_e.name, "_ctrl"}, 128'(control_out), 128'(mon_e.ctrl));
          if (mon_e.chk_data) begin
            check({mon_e.name, "_data"}, 128'(data_out), 128'(mon_e.data));
          end
          check({mon_e.name, "_fault"}, 128'(mem_fault), 128'(mon_e.fault));
        end
      end
    end
  end

  task automatic idle(input string nm);
    exp_t e;
    in_valid   = 1'b0;
    data_in    = '0;
    control_in = '0;
    e.ctrl = '0; e.data = '0; e.chk_data = 1'b0; e.fault = 1'b0; e.name = nm;
    exp_q.push_back(e);
    @(posedge clock); #1;
  endtask

  task automatic do_op(input string nm, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                       input logic m2r, input int ack, input logic [31:0] rdat,
                       input mem_wb_control_t ectrl, input logic [31:0] erd,
                       input logic efault, input int estall, input int ereq);
    exp_t e;
    int   n;
    ack_at     = ack;
    ack_rdata  = rdat;
    exp_addr   = alu;
    exp_we     = mw;
    exp_wdata  = mw ? wd : 32'h0;
    req_cnt    = 0;
    in_valid   = 1'b1;
    data_in    = '{ALU_result: alu, write_data: wd, rd: rd};
    control_in = '{MEM_read: mr, MEM_write: mw, WB_reg_write: rw, WB_mem_to_reg: m2r};
    e.ctrl = ectrl; e.data = '{read_data: erd, ALU_result: alu, rd: rd};
    e.chk_data = 1'b1; e.fault = efault; e.name = nm;
    exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clock);
      if (stall) n++;
    end while (stall && n <= 100);
    if (n > 100) begin
      checks++;
      errors++;
      $display("FAIL %s_stall_timeout: stall still high after %0d cycles, required release", nm, n);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    check({nm, "_stall_cycles"}, 128'(n), 128'(estall));
    check({nm, "_req_cycles"}, 128'(req_cnt), 128'(ereq));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    in_valid   = 1'b0;
    data_in    = '0;
    control_in = '0;
    #2;
    check("rst_mem_req", 128'(mem_req), 128'(0));
    check("rst_mem_we", 128'(mem_we), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    check("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    check("rst_mem_fault", 128'(mem_fault), 128'(0));
    check("rst_stall", 128'(stall), 128'(0));
    check("rst_ctrl", 128'(control_out), 128'(0));
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    idle("idle0");
    //     name        alu           wd            rd  mr mw rw m2r ack rdata        ctrl   read_data     flt stl req
    do_op("alu",      32'd12345,    32'h0,        31, 0, 0, 1, 0,  0,  32'h0,       2'b10, 32'h0,        0,  0,  0);
    do_op("load100",  32'h100,      32'h5555,     5,  1, 0, 1, 1,  3,  32'd1234,    2'b11, 32'd1234,     0,  4,  3);
    do_op("store40",  32'h40,       32'hDEADBEEF, 7,  0, 1, 0, 0,  2,  32'h77,      2'b00, 32'h0,        0,  3,  2);
    do_op("misalign", 32'h102,      32'h0,        9,  1, 0, 1, 1,  0,  32'h0,       2'b01, 32'h0,        1,  0,  0);
    do_op("timeout",  32'h200,      32'h0,        3,  1, 0, 1, 1,  0,  32'h0,       2'b01, 32'h0,        1,  17, 16);
    do_op("ack16",    32'h204,      32'h0,        4,  1, 0, 1, 1,  16, 32'hCAFEF00D, 2'b11, 32'hCAFEF00D, 0,  17, 16);
    do_op("rdwr",     32'h80,       32'h12345678, 2,  1, 1, 1, 0,  1,  32'hFFFF,    2'b10, 32'h0,        0,  2,  1);
    idle("idle1");
    do_op("mis_st",   32'h41,       32'h11,       6,  0, 1, 1, 0,  0,  32'h0,       2'b00, 32'h0,        1,  0,  0);
    do_op("alu2",     32'hFFFF0003, 32'h0,        1,  0, 0, 1, 0,  0,  32'h0,       2'b10, 32'h0,        0,  0,  0);

    // Reset in the middle of an outstanding load: bus drops at once, no RESP follows.
    ack_at     = 0;
    exp_addr   = 32'h400;
    exp_we     = 1'b0;
    exp_wdata  = 32'h0;
    req_cnt    = 0;
    in_valid   = 1'b1;
    data_in    = '{ALU_result: 32'h400, write_data: 32'h0, rd: 5'd8};
    control_in = '{MEM_read: 1'b1, MEM_write: 1'b0, WB_reg_write: 1'b1, WB_mem_to_reg: 1'b1};
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_mem_req", 128'(mem_req), 128'(0));
    check("midrst_stall", 128'(stall), 128'(0));
    in_valid   = 1'b0;
    data_in    = '0;
    control_in = '0;
    @(posedge clock); @(posedge clock); #1;
    reset   = 1'b0;
    req_cnt = 0;
    idle("post_rst0");
    idle("post_rst1");
    idle("post_rst2");
    check("post_rst_no_req", 128'(req_cnt), 128'(0));
    do_op("load300",  32'h300,      32'h0,        10, 1, 0, 1, 1,  1,  32'hA5A5,    2'b11, 32'hA5A5,     0,  2,  1);
    idle("idle_end");

    done = 1'b1;
    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
